// File: rtl/rom_upload_reader.sv
// Upload (readback) reader: serves HPS ioctl byte reads from SDRAM port1 using a
// toggle req/ack handshake. A one-word cache lets both bytes of a word come from one access.
module rom_upload_reader #(
    parameter logic [24:0] BASE_ADDR   = 25'h0000000,
    parameter logic [24:0] UPLOAD_SIZE = 25'h001C320,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic        port_req,
    input  logic        port_ack,
    output logic [22:0] port_a,
    output logic [1:0]  port_ds,
    output logic        port_we,
    input  logic [15:0] port_q,
    output logic        busy,
    output logic        err,
    output logic [24:0] bytes_done
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_DELIVER} state_t;

    state_t      state_q, state_d;
    logic        upload_q;
    logic [24:0] addr_q, addr_d;
    logic [15:0] cache_q, cache_d;
    logic [22:0] tag_q, tag_d;
    logic        valid_q, valid_d;
    logic [7:0]  din_q, din_d;
    logic        wait_q, wait_d;
    logic        req_q, req_d;
    logic [22:0] port_a_q, port_a_d;
    logic        err_q, err_d;
    logic [24:0] bytes_q, bytes_d;

    logic [24:0] eff_addr;
    logic        session_rise;
    logic        rd_ok;
    logic        hit;
    logic        deliver;
    logic [24:0] bytes_base;

    function automatic logic [7:0] sel_byte(input logic [15:0] w, input logic odd);
        return odd ? w[15:8] : w[7:0];
    endfunction

    assign eff_addr     = ioctl_addr + BASE_ADDR;
    assign session_rise = ioctl_upload & ~upload_q;
    assign rd_ok        = ioctl_rd & ioctl_upload;
    // A session start invalidates the cache in the same cycle it is seen.
    assign hit          = valid_q && !session_rise && (tag_q == eff_addr[23:1]);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cache_d    = cache_q;
        tag_d      = tag_q;
        valid_d    = valid_q;
        din_d      = din_q;
        wait_d     = wait_q;
        req_d      = req_q;
        port_a_d   = port_a_q;
        err_d      = err_q;
        deliver    = 1'b0;
        bytes_base = bytes_q;

        if (session_rise) begin
            valid_d    = 1'b0;
            err_d      = 1'b0;
            bytes_base = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (rd_ok) begin
                    if (ioctl_addr >= UPLOAD_SIZE) begin
                        din_d   = FILL_BYTE;
                        deliver = 1'b1;
                    end else if (hit) begin
                        din_d   = sel_byte(cache_q, eff_addr[0]);
                        deliver = 1'b1;
                    end else begin
                        addr_d  = eff_addr;
                        wait_d  = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                port_a_d = addr_q[23:1];
                req_d    = ~req_q;
                state_d  = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // No timeout: the handshake must stay balanced, so we wait for the ack.
                if (port_ack == req_q) begin
                    cache_d = port_q;
                    tag_d   = addr_q[23:1];
                    valid_d = 1'b1;
                    state_d = S_DELIVER;
                end
            end
            S_DELIVER: begin
                din_d   = sel_byte(cache_q, addr_q[0]);
                wait_d  = 1'b0;
                deliver = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (rd_ok && state_q != S_IDLE) begin
            err_d = 1'b1;
        end

        bytes_d = bytes_base;
        if (deliver && bytes_base != 25'h1FFFFFF) begin
            bytes_d = bytes_base + 25'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            upload_q <= 1'b0;
            addr_q   <= '0;
            cache_q  <= '0;
            tag_q    <= '0;
            valid_q  <= 1'b0;
            din_q    <= '0;
            wait_q   <= 1'b0;
            req_q    <= 1'b0;
            port_a_q <= '0;
            err_q    <= 1'b0;
            bytes_q  <= '0;
        end else begin
            state_q  <= state_d;
            upload_q <= ioctl_upload;
            addr_q   <= addr_d;
            cache_q  <= cache_d;
            tag_q    <= tag_d;
            valid_q  <= valid_d;
            din_q    <= din_d;
            wait_q   <= wait_d;
            req_q    <= req_d;
            port_a_q <= port_a_d;
            err_q    <= err_d;
            bytes_q  <= bytes_d;
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign port_req   = req_q;
    assign port_a     = port_a_q;
    assign port_ds    = 2'b11;
    assign port_we    = 1'b0;
    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;
    assign bytes_done = bytes_q;

endmodule
